slave_port_param: RTL and testbench

Parametrised serial-bus slave port. Receives bit-serial write and read frames from the bus master and decodes the address against a configurable base/mask window. Presents captured address and data to the local register/memory side, and returns read data bit-serially under a per-bit ready/valid handshake. It generalises the fixed 12-bit-address, 8-bit-data slave to arbitrary widths, adds address decoding, frame-abort detection and stallable read responses.

---
 rtl/serial_bus_pkg.sv | 27 ++
 rtl/sbus_shift_reg.sv | 32 +++
 rtl/slave_port_param.sv | 275 +++++++++++++++++++++++++++
 tb/tb_slave_port_param.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_bus_pkg.sv
// Shared types and helpers for the serial-bus slave port: FSM state encoding,
// bit-counter sizing and the even-parity helper used by the optional parity
// mode (SLAVE_PORT_PARITY_EN).
package serial_bus_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RX_WR     = 3'd1,
        RX_RD     = 3'd2,
        WAIT_DATA = 3'd3,
        RESP      = 3'd4
    } sbus_state_e;

    // Widest vector the parity helper accepts; callers zero-extend into it.
    localparam int unsigned PARITY_MAX_WIDTH = 64;

    // Counter width able to hold every value 0..max_len.
    function automatic int unsigned bit_cnt_width(input int unsigned max_len);
        return $clog2(max_len + 32'd1);
    endfunction

    // Even-parity bit: the value that makes the total number of ones even.
    function automatic logic even_parity(input logic [PARITY_MAX_WIDTH-1:0] vec);
        return ^vec;
    endfunction

endpackage

// File: rtl/sbus_shift_reg.sv
// MSB-first shift register with parallel load. Load wins over shift; the
// serial input enters at bit 0 so the first bit shifted in ends up as MSB.
module sbus_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_r;

    // Shift/load register; cleared by reset so no stale bits leak out.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= {WIDTH{1'b0}};
        end else if (load) begin
            q_r <= load_data;
        end else if (shift_en) begin
            q_r <= {q_r[WIDTH-2:0], serial_in};
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/slave_port_param.sv
// Parametrised bit-serial bus slave port with base/mask address decode,
// frame-abort detection and a stallable serial read response.
// Optional feature: define SLAVE_PORT_PARITY_EN to add an even-parity bit to
// write frames, read frames and read responses.
module slave_port_param
    import serial_bus_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 12,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 12'h800,
    parameter logic [ADDR_WIDTH-1:0] ADDR_MASK  = 12'hF00
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_enable,
    input  logic                  read_enable,
    input  logic                  m_valid,
    input  logic                  rx_address,
    input  logic                  rx_data,
    input  logic                  m_ready,
    input  logic [DATA_WIDTH-1:0] data_input,
    input  logic                  data_input_valid,
    output logic                  s_ready,
    output logic                  s_valid,
    output logic                  tx_data,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  wr_strobe,
    output logic                  rd_req,
    output logic                  frame_err
);

`ifdef SLAVE_PORT_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    localparam int FRAME_LEN = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CNT_W     = int'(bit_cnt_width(FRAME_LEN + PAR_BITS));
    localparam int TX_W      = DATA_WIDTH + PAR_BITS;

    localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(FRAME_LEN - 1 + PAR_BITS);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(ADDR_WIDTH - 1 + PAR_BITS);
    localparam logic [CNT_W-1:0] TX_LAST  = CNT_W'(TX_W - 1);
    localparam logic [CNT_W-1:0] ADDR_CNT = CNT_W'(ADDR_WIDTH);
    localparam logic [CNT_W-1:0] DATA_CNT = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    sbus_state_e            state_r, state_next_s;
    logic [CNT_W-1:0]       cnt_r, cnt_next_s;

    logic [ADDR_WIDTH-1:0]  addr_q_s, addr_next_s;
    logic [DATA_WIDTH-1:0]  data_q_s, data_next_s;
    logic [TX_W-1:0]        tx_q_s, tx_load_data_s;

    logic addr_shift_s, data_shift_s, tx_load_s, tx_shift_s;
    logic decode_hit_s, par_addr_ok_s, par_data_ok_s;
    logic wr_strobe_next_s, rd_req_next_s, frame_err_next_s;
    logic addr_commit_s, data_commit_s;

    logic                  s_ready_r, s_valid_r, wr_strobe_r, rd_req_r, frame_err_r;
    logic [ADDR_WIDTH-1:0] address_r;
    logic [DATA_WIDTH-1:0] data_r;

    sbus_shift_reg #(.WIDTH(ADDR_WIDTH)) u_addr_rx (
        .clk       (clk),
        .rst       (rst),
        .load      (1'b0),
        .load_data ({ADDR_WIDTH{1'b0}}),
        .shift_en  (addr_shift_s),
        .serial_in (rx_address),
        .q         (addr_q_s)
    );

    sbus_shift_reg #(.WIDTH(DATA_WIDTH)) u_data_rx (
        .clk       (clk),
        .rst       (rst),
        .load      (1'b0),
        .load_data ({DATA_WIDTH{1'b0}}),
        .shift_en  (data_shift_s),
        .serial_in (rx_data),
        .q         (data_q_s)
    );

    // Zeros shift in behind the response, so the register drains to 0 and
    // tx_data idles low once a response completes.
    sbus_shift_reg #(.WIDTH(TX_W)) u_data_tx (
        .clk       (clk),
        .rst       (rst),
        .load      (tx_load_s),
        .load_data (tx_load_data_s),
        .shift_en  (tx_shift_s),
        .serial_in (1'b0),
        .q         (tx_q_s)
    );

    // Value the rx registers will hold after this edge; the decode on the
    // final bit edge must see the complete address including that bit.
    assign addr_next_s  = addr_shift_s ? {addr_q_s[ADDR_WIDTH-2:0], rx_address} : addr_q_s;
    assign data_next_s  = data_shift_s ? {data_q_s[DATA_WIDTH-2:0], rx_data} : data_q_s;
    assign decode_hit_s = ((addr_next_s & ADDR_MASK) == (BASE_ADDR & ADDR_MASK));

`ifdef SLAVE_PORT_PARITY_EN
    // The parity cycle follows the last payload bit, so the rx registers are
    // already complete when it is checked.
    assign par_addr_ok_s  = (rx_address == even_parity(PARITY_MAX_WIDTH'(addr_q_s)));
    assign par_data_ok_s  = (rx_data == even_parity(PARITY_MAX_WIDTH'(data_q_s)));
    assign tx_load_data_s = {data_input, even_parity(PARITY_MAX_WIDTH'(data_input))};
`else
    assign par_addr_ok_s  = 1'b1;
    assign par_data_ok_s  = 1'b1;
    assign tx_load_data_s = data_input;
`endif

    // FSM state and bit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Next-state, counter, shift controls and next values of pulse outputs.
    always_comb begin
        state_next_s     = state_r;
        cnt_next_s       = cnt_r;
        addr_shift_s     = 1'b0;
        data_shift_s     = 1'b0;
        tx_load_s        = 1'b0;
        tx_shift_s       = 1'b0;
        wr_strobe_next_s = 1'b0;
        rd_req_next_s    = 1'b0;
        frame_err_next_s = 1'b0;
        addr_commit_s    = 1'b0;
        data_commit_s    = 1'b0;

        case (state_r)
            IDLE: begin
                if (write_enable && read_enable) begin
                    frame_err_next_s = 1'b1;
                end else if (m_valid && write_enable) begin
                    addr_shift_s = 1'b1;
                    data_shift_s = 1'b1;
                    cnt_next_s   = CNT_ONE;
                    state_next_s = RX_WR;
                end else if (m_valid && read_enable) begin
                    addr_shift_s = 1'b1;
                    cnt_next_s   = CNT_ONE;
                    state_next_s = RX_RD;
                end else begin
                    cnt_next_s = {CNT_W{1'b0}};
                end
            end

            RX_WR: begin
                if (!m_valid) begin
                    frame_err_next_s = 1'b1;
                    state_next_s     = IDLE;
                end else begin
                    addr_shift_s = (cnt_r < ADDR_CNT);
                    data_shift_s = (cnt_r < DATA_CNT);
                    if (cnt_r == WR_LAST) begin
                        state_next_s = IDLE;
                        if (!(par_addr_ok_s && par_data_ok_s)) begin
                            frame_err_next_s = 1'b1;
                        end else if (decode_hit_s) begin
                            addr_commit_s    = 1'b1;
                            data_commit_s    = 1'b1;
                            wr_strobe_next_s = 1'b1;
                        end else begin
                            wr_strobe_next_s = 1'b0;
                        end
                    end else begin
                        cnt_next_s = cnt_r + CNT_ONE;
                    end
                end
            end

            RX_RD: begin
                if (!m_valid) begin
                    frame_err_next_s = 1'b1;
                    state_next_s     = IDLE;
                end else begin
                    addr_shift_s = (cnt_r < ADDR_CNT);
                    if (cnt_r == RD_LAST) begin
                        if (!par_addr_ok_s) begin
                            frame_err_next_s = 1'b1;
                            state_next_s     = IDLE;
                        end else if (decode_hit_s) begin
                            addr_commit_s = 1'b1;
                            rd_req_next_s = 1'b1;
                            state_next_s  = WAIT_DATA;
                        end else begin
                            state_next_s = IDLE;
                        end
                    end else begin
                        cnt_next_s = cnt_r + CNT_ONE;
                    end
                end
            end

            WAIT_DATA: begin
                if (data_input_valid) begin
                    tx_load_s    = 1'b1;
                    cnt_next_s   = {CNT_W{1'b0}};
                    state_next_s = RESP;
                end else begin
                    state_next_s = WAIT_DATA;
                end
            end

            RESP: begin
                if (m_ready) begin
                    tx_shift_s = 1'b1;
                    if (cnt_r == TX_LAST) begin
                        cnt_next_s   = {CNT_W{1'b0}};
                        state_next_s = IDLE;
                    end else begin
                        cnt_next_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    tx_shift_s = 1'b0;
                end
            end

            default: begin
                state_next_s = IDLE;
                cnt_next_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Registered outputs; handshake flags follow the upcoming state.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_ready_r   <= 1'b0;
            s_valid_r   <= 1'b0;
            wr_strobe_r <= 1'b0;
            rd_req_r    <= 1'b0;
            frame_err_r <= 1'b0;
            address_r   <= {ADDR_WIDTH{1'b0}};
            data_r      <= {DATA_WIDTH{1'b0}};
        end else begin
            s_ready_r   <= (state_next_s == IDLE);
            s_valid_r   <= (state_next_s == RESP);
            wr_strobe_r <= wr_strobe_next_s;
            rd_req_r    <= rd_req_next_s;
            frame_err_r <= frame_err_next_s;
            if (addr_commit_s) begin
                address_r <= addr_next_s;
            end else begin
                address_r <= address_r;
            end
            if (data_commit_s) begin
                data_r <= data_next_s;
            end else begin
                data_r <= data_r;
            end
        end
    end

    assign s_ready   = s_ready_r;
    assign s_valid   = s_valid_r;
    assign tx_data   = tx_q_s[TX_W-1];
    assign address   = address_r;
    assign data      = data_r;
    assign wr_strobe = wr_strobe_r;
    assign rd_req    = rd_req_r;
    assign frame_err = frame_err_r;

endmodule

// File: tb/tb_slave_port_param.sv
// Scoreboard bench for slave_port_param (default parameters). Stimulus pushes
// expected wr_strobe / rd_req / frame_err events and tx bits into queues; a
// negedge monitor pops and compares whenever the DUT presents them.
module tb_slave_port_param;

`ifdef SLAVE_PORT_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    typedef struct {
        logic [11:0] a;
        logic [7:0]  d;
        int          cyc;
    } evt_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        write_enable, read_enable, m_valid, rx_address, rx_data, m_ready;
    logic [7:0]  data_input;
    logic        data_input_valid;
    logic        s_ready, s_valid, tx_data, wr_strobe, rd_req, frame_err;
    logic [11:0] address;
    logic [7:0]  data;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    evt_t wr_q[$];
    evt_t rd_q[$];
    int   err_q[$];
    logic tx_q[$];

    slave_port_param dut (
        .clk              (clk),
        .rst              (rst),
        .write_enable     (write_enable),
        .read_enable      (read_enable),
        .m_valid          (m_valid),
        .rx_address       (rx_address),
        .rx_data          (rx_data),
        .m_ready          (m_ready),
        .data_input       (data_input),
        .data_input_valid (data_input_valid),
        .s_ready          (s_ready),
        .s_valid          (s_valid),
        .tx_data          (tx_data),
        .address          (address),
        .data             (data),
        .wr_strobe        (wr_strobe),
        .rd_req           (rd_req),
        .frame_err        (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every presented event against the scoreboard.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (wr_strobe) begin
                chk("wr_strobe expected", 32'(wr_q.size() > 0), 32'd1);
                if (wr_q.size() > 0) begin
                    evt_t e;
                    e = wr_q.pop_front();
                    chk("wr address", 32'(address), 32'(e.a));
                    chk("wr data", 32'(data), 32'(e.d));
                    chk("wr cycle", 32'(cyc), 32'(e.cyc));
                    chk("wr s_ready", 32'(s_ready), 32'd1);
                end
            end
            if (rd_req) begin
                chk("rd_req expected", 32'(rd_q.size() > 0), 32'd1);
                if (rd_q.size() > 0) begin
                    evt_t e;
                    e = rd_q.pop_front();
                    chk("rd address", 32'(address), 32'(e.a));
                    chk("rd cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            if (frame_err) begin
                chk("frame_err expected", 32'(err_q.size() > 0), 32'd1);
                if (err_q.size() > 0) begin
                    int c;
                    c = err_q.pop_front();
                    chk("err cycle", 32'(cyc), 32'(c));
                    chk("err s_ready", 32'(s_ready), 32'd1);
                end
            end
            if (s_valid) begin
                chk("s_valid expected", 32'(tx_q.size() > 0), 32'd1);
                if (tx_q.size() > 0) begin
                    if (m_ready) begin
                        logic b;
                        b = tx_q.pop_front();
                        chk("tx_data accept", 32'(tx_data), 32'(b));
                    end else begin
                        chk("tx_data stall", 32'(tx_data), 32'(tx_q[0]));
                    end
                end
            end
        end
    end

    task automatic idle_inputs();
        write_enable = 1'b0;
        read_enable  = 1'b0;
        m_valid      = 1'b0;
        rx_address   = 1'b0;
        rx_data      = 1'b0;
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 50 && s_ready !== 1'b1; k++) begin
            @(posedge clk); #1;
        end
        chk("s_ready wait", 32'(s_ready), 32'd1);
    endtask

    // Drive one frame MSB first; abort_bit < 0 means no abort.
    task automatic send_frame(input bit is_wr, input logic [11:0] a, input logic [7:0] d,
                              input int abort_bit, input bit bad_par);
        int n;
        n = (is_wr ? 12 : 12) + PB;
        for (int i = 0; i < n; i++) begin
            m_valid      = (i != abort_bit);
            write_enable = is_wr && (i == 0);
            read_enable  = !is_wr && (i == 0);
            if (PB == 1 && i == n - 1) begin
                rx_address = (^a) ^ bad_par;
                rx_data    = is_wr ? (^d) : 1'b0;
            end else begin
                rx_address = a[11-i];
                rx_data    = (is_wr && i < 8) ? d[7-i] : 1'b0;
            end
            @(posedge clk); #1;
            if (i == abort_bit) break;
        end
        idle_inputs();
    endtask

    task automatic push_tx(input logic [7:0] d);
        for (int i = 7; i >= 0; i--) tx_q.push_back(d[i]);
        if (PB == 1) tx_q.push_back(^d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        rst = 1'b1;
        idle_inputs();
        m_ready          = 1'b0;
        data_input       = 8'h00;
        data_input_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset s_ready", 32'(s_ready), 32'd0);
        chk("reset s_valid", 32'(s_valid), 32'd0);
        chk("reset tx_data", 32'(tx_data), 32'd0);
        chk("reset address", 32'(address), 32'd0);
        chk("reset data", 32'(data), 32'd0);
        chk("reset pulses", 32'({wr_strobe, rd_req, frame_err}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("s_ready after reset", 32'(s_ready), 32'd1);

        // In-window write.
        t0 = cyc + 1;
        wr_q.push_back('{a: 12'h8A5, d: 8'hB3, cyc: t0 + 11 + PB});
        send_frame(1'b1, 12'h8A5, 8'hB3, -1, 1'b0);
        wait_ready();

        // Out-of-window write is dropped.
        send_frame(1'b1, 12'h3A5, 8'h11, -1, 1'b0);
        wait_ready();
        chk("addr after miss", 32'(address), 32'h8A5);
        chk("data after miss", 32'(data), 32'hB3);

        // Abort at bit 5.
        t0 = cyc + 1;
        err_q.push_back(t0 + 5);
        send_frame(1'b1, 12'h8A5, 8'h5A, 5, 1'b0);
        chk("s_ready after abort", 32'(s_ready), 32'd1);
        chk("addr after abort", 32'(address), 32'h8A5);
        chk("data after abort", 32'(data), 32'hB3);

        // Both enables high.
        t0 = cyc + 1;
        err_q.push_back(t0);
        m_valid = 1'b1; write_enable = 1'b1; read_enable = 1'b1;
        @(posedge clk); #1;
        idle_inputs();
        chk("s_ready after dual enable", 32'(s_ready), 32'd1);

        // Read 0x812 with late data and a stalling master.
        t0 = cyc + 1;
        rd_q.push_back('{a: 12'h812, d: 8'h00, cyc: t0 + 11 + PB});
        push_tx(8'hCC);
        send_frame(1'b0, 12'h812, 8'h00, -1, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        data_input = 8'hCC; data_input_valid = 1'b1;
        @(posedge clk); #1;
        data_input_valid = 1'b0;
        chk("s_valid after latch", 32'(s_valid), 32'd1);
        for (int k = 0; k < 24; k++) begin
            m_ready = (k % 2 == 0);
            @(posedge clk); #1;
        end
        m_ready = 1'b0;
        chk("s_valid after response", 32'(s_valid), 32'd0);
        wait_ready();

        // Out-of-window read: no response.
        send_frame(1'b0, 12'h312, 8'h00, -1, 1'b0);
        wait_ready();
        chk("addr after read miss", 32'(address), 32'h812);

        // Reset during a response after three accepted bits.
        send_frame(1'b0, 12'h8F0, 8'h00, -1, 1'b0);
        rd_q.push_back('{a: 12'h8F0, d: 8'h00, cyc: cyc});
        data_input = 8'hA5; data_input_valid = 1'b1; m_ready = 1'b1;
        push_tx(8'hA5);
        @(posedge clk); #1;
        data_input_valid = 1'b0;
        chk("s_valid resp start", 32'(s_valid), 32'd1);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1; m_ready = 1'b0;
        @(posedge clk); #1;
        tx_q.delete();
        chk("rst s_valid", 32'(s_valid), 32'd0);
        chk("rst s_ready", 32'(s_ready), 32'd0);
        chk("rst tx_data", 32'(tx_data), 32'd0);
        chk("rst address", 32'(address), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("s_ready after rst", 32'(s_ready), 32'd1);
        chk("tx_data after rst", 32'(tx_data), 32'd0);
        chk("s_valid after rst", 32'(s_valid), 32'd0);

`ifdef SLAVE_PORT_PARITY_EN
        t0 = cyc + 1;
        err_q.push_back(t0 + 12);
        send_frame(1'b1, 12'h8A5, 8'hB3, -1, 1'b1);
        wait_ready();
        t0 = cyc + 1;
        wr_q.push_back('{a: 12'h8A5, d: 8'hB3, cyc: t0 + 12});
        send_frame(1'b1, 12'h8A5, 8'hB3, -1, 1'b0);
        wait_ready();
`endif

        repeat (5) begin @(posedge clk); #1; end
        chk("wr events left", 32'(wr_q.size()), 32'd0);
        chk("rd events left", 32'(rd_q.size()), 32'd0);
        chk("err events left", 32'(err_q.size()), 32'd0);
        chk("tx bits left", 32'(tx_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
